// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite fetch path.
// Defaults mirror the standard 32x32 sprite sheet with magenta-key transparency.
package sprite_pkg;
    localparam int SPR_W_DEF = 32;
    localparam int SPR_H_DEF = 32;
    localparam int SPR_SIZE = SPR_W_DEF * SPR_H_DEF;
    localparam int LATENCY = 3;
    localparam logic [15:0] TRANSP_KEY_DEF = 16'hF81F;

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction
endpackage

// File: rtl/rr_pick2.sv
// Round-robin picker returning up to two distinct winners, scanning upward from ptr.
// Purely combinational; a channel never wins both slots.
module rr_pick2 #(
    parameter int NUM_CH = 4,
    parameter int PW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     gnt_a,
    output logic              gnt_a_valid,
    output logic [PW-1:0]     gnt_b,
    output logic              gnt_b_valid
);
    always_comb begin
        int idx;
        gnt_a = '0;
        gnt_a_valid = 1'b0;
        gnt_b = '0;
        gnt_b_valid = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (req[idx]) begin
                if (!gnt_a_valid) begin
                    gnt_a = PW'(idx);
                    gnt_a_valid = 1'b1;
                end else if (!gnt_b_valid) begin
                    gnt_b = PW'(idx);
                    gnt_b_valid = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sprite_rom_dp.sv
// Dual-port sprite ROM, one registered read per port per cycle, no stalls.
// Mask contents: word[a] = a, except one key-coloured pixel at 16'h0865.
module sprite_rom_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] TRANSP_KEY = 16'hF81F
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b
);
    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(16'h0865))
            return TRANSP_KEY;
        return DATA_WIDTH'(a);
    endfunction

    always_ff @(posedge clk) begin
        q_a <= rom_word(addr_a);
        q_b <= rom_word(addr_b);
    end
endmodule

// File: rtl/sprite_fetch_mc.sv
// Multi-channel sprite pixel fetch: two round-robin grants per cycle onto a dual-port ROM.
// Fixed 3-cycle response latency, full throughput; responses cannot be stalled.
module sprite_fetch_mc
    import sprite_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int ID_WIDTH   = 3,
    parameter logic [DATA_WIDTH-1:0] TRANSP_KEY = DATA_WIDTH'(TRANSP_KEY_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*ID_WIDTH-1:0]   req_id,
    input  logic [NUM_CH*8-1:0]          req_x,
    input  logic [NUM_CH*8-1:0]          req_y,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_CH-1:0]            rsp_transparent
);
    localparam int PW = $clog2(NUM_CH);
    localparam int SPR_SZ = SPR_W * SPR_H;

    logic [PW-1:0]         rr_ptr, gnt_a, gnt_b;
    logic                  gnt_a_valid, gnt_b_valid;
    logic [NUM_CH-1:0]     req_live;
    logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
    logic [NUM_CH-1:0]     ch_oob;

    logic [ADDR_WIDTH-1:0] s1_addr_a, s1_addr_b;
    logic [PW-1:0]         s1_tag_a, s1_tag_b, s2_tag_a, s2_tag_b;
    logic                  s1_vld_a, s1_vld_b, s2_vld_a, s2_vld_b;
    logic                  s1_oob_a, s1_oob_b, s2_oob_a, s2_oob_b;
    logic [DATA_WIDTH-1:0] q_a, q_b, pix_a, pix_b;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NUM_CH - 1)) ? '0 : i + 1'b1;
    endfunction

    // Grants are suppressed during reset so nothing is accepted into a squashed pipe.
    assign req_live = reset ? '0 : req_valid;

    rr_pick2 #(.NUM_CH(NUM_CH)) u_pick (
        .req         (req_live),
        .ptr         (rr_ptr),
        .gnt_a       (gnt_a),
        .gnt_a_valid (gnt_a_valid),
        .gnt_b       (gnt_b),
        .gnt_b_valid (gnt_b_valid)
    );

    always_comb begin
        req_ready = '0;
        if (gnt_a_valid)
            req_ready[gnt_a] = 1'b1;
        if (gnt_b_valid)
            req_ready[gnt_b] = 1'b1;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_oob[c] = (32'(req_x[ch_lsb(c, 8) +: 8]) >= 32'(SPR_W)) ||
                        (32'(req_y[ch_lsb(c, 8) +: 8]) >= 32'(SPR_H));
            ch_addr[c] = ch_oob[c] ? '0 :
                ADDR_WIDTH'(32'(req_id[ch_lsb(c, ID_WIDTH) +: ID_WIDTH]) * 32'(SPR_SZ) +
                            32'(req_y[ch_lsb(c, 8) +: 8]) * 32'(SPR_W) +
                            32'(req_x[ch_lsb(c, 8) +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
            s2_vld_a <= 1'b0;
            s2_vld_b <= 1'b0;
        end else begin
            s1_vld_a <= gnt_a_valid;
            s1_vld_b <= gnt_b_valid;
            s2_vld_a <= s1_vld_a;
            s2_vld_b <= s1_vld_b;
            if (gnt_b_valid)
                rr_ptr <= wrap_inc(gnt_b);
            else if (gnt_a_valid)
                rr_ptr <= wrap_inc(gnt_a);
        end
    end

    always_ff @(posedge clk) begin
        s1_addr_a <= ch_addr[gnt_a];
        s1_addr_b <= ch_addr[gnt_b];
        s1_tag_a  <= gnt_a;
        s1_tag_b  <= gnt_b;
        s1_oob_a  <= ch_oob[gnt_a];
        s1_oob_b  <= ch_oob[gnt_b];
        s2_tag_a  <= s1_tag_a;
        s2_tag_b  <= s1_tag_b;
        s2_oob_a  <= s1_oob_a;
        s2_oob_b  <= s1_oob_b;
    end

    sprite_rom_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TRANSP_KEY (TRANSP_KEY)
    ) u_rom (
        .clk    (clk),
        .addr_a (s1_addr_a),
        .addr_b (s1_addr_b),
        .q_a    (q_a),
        .q_b    (q_b)
    );

    assign pix_a = s2_oob_a ? TRANSP_KEY : q_a;
    assign pix_b = s2_oob_b ? TRANSP_KEY : q_b;

    // Ports A and B always carry different channels, so the two writes never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_transparent <= '0;
        end else begin
            rsp_valid <= '0;
            if (s2_vld_a) begin
                rsp_valid[s2_tag_a] <= 1'b1;
                rsp_data[ch_lsb(int'(s2_tag_a), DATA_WIDTH) +: DATA_WIDTH] <= pix_a;
                rsp_transparent[s2_tag_a] <= (pix_a == TRANSP_KEY);
            end
            if (s2_vld_b) begin
                rsp_valid[s2_tag_b] <= 1'b1;
                rsp_data[ch_lsb(int'(s2_tag_b), DATA_WIDTH) +: DATA_WIDTH] <= pix_b;
                rsp_transparent[s2_tag_b] <= (pix_b == TRANSP_KEY);
            end
        end
    end
endmodule

// File: tb/tb_sprite_fetch_mc.sv
// Randomised and directed bench for sprite_fetch_mc against a cycle-level reference model.
module tb_sprite_fetch_mc;
    localparam int NCH = 4;
    localparam logic [15:0] KEY = 16'hF81F;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  req_valid = '0;
    logic [NCH-1:0]  req_ready;
    logic [NCH*3-1:0] req_id = '0;
    logic [NCH*8-1:0] req_x = '0;
    logic [NCH*8-1:0] req_y = '0;
    logic [NCH-1:0]  rsp_valid;
    logic [NCH*16-1:0] rsp_data;
    logic [NCH-1:0]  rsp_transparent;

    always #5 clk = ~clk;

    sprite_fetch_mc dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_id          (req_id),
        .req_x           (req_x),
        .req_y           (req_y),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_transparent (rsp_transparent)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [NCH-1:0] s_v;
    int s_id[NCH], s_x[NCH], s_y[NCH];

    int             m_ptr;
    logic [NCH-1:0] pend_v[4];
    logic [15:0]    pend_d[4][NCH];
    logic [15:0]    held_d[NCH];

    logic [NCH-1:0]    obs_ready, obs_v, obs_t, exp_ready, exp_v, exp_t;
    logic [NCH*16-1:0] obs_d, exp_d;

    function automatic logic [15:0] model_pix(input int id, input int x, input int y);
        int a;
        logic [15:0] w;
        if (x >= 32 || y >= 32)
            return KEY;
        a = id * 1024 + y * 32 + x;
        w = a[15:0];
        return (w == 16'h0865) ? KEY : w;
    endfunction

    // One clock: drive s_* arrays, sample outputs at negedge, advance the reference model.
    task automatic step();
        int slot, nxt, cnt, last, c;
        for (int k = 0; k < NCH; k++) begin
            req_id[k*3 +: 3] = 3'(s_id[k]);
            req_x[k*8 +: 8]  = 8'(s_x[k]);
            req_y[k*8 +: 8]  = 8'(s_y[k]);
        end
        req_valid = s_v;
        @(negedge clk);
        obs_ready = req_ready;
        obs_v = rsp_valid;
        obs_d = rsp_data;
        obs_t = rsp_transparent;
        slot = cyc % 4;
        exp_v = pend_v[slot];
        for (int k = 0; k < NCH; k++) begin
            if (exp_v[k])
                held_d[k] = pend_d[slot][k];
            exp_d[k*16 +: 16] = held_d[k];
            exp_t[k] = (held_d[k] == KEY);
        end
        pend_v[slot] = '0;
        exp_ready = '0;
        cnt = 0;
        last = 0;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                c = (m_ptr + i) % NCH;
                if (s_v[c] && cnt < 2) begin
                    exp_ready[c] = 1'b1;
                    last = c;
                    cnt++;
                end
            end
        end
        if (reset) begin
            for (int s = 0; s < 4; s++) pend_v[s] = '0;
            for (int k = 0; k < NCH; k++) held_d[k] = '0;
            m_ptr = 0;
        end else begin
            nxt = (cyc + 3) % 4;
            pend_v[nxt] = exp_ready;
            for (int k = 0; k < NCH; k++)
                pend_d[nxt][k] = model_pix(s_id[k], s_x[k], s_y[k]);
            if (cnt > 0)
                m_ptr = (last + 1) % NCH;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        s_v = '0;
        for (int k = 0; k < NCH; k++) begin
            s_id[k] = 0; s_x[k] = 0; s_y[k] = 0;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) pend_v[s] = '0;
        for (int k = 0; k < NCH; k++) held_d[k] = '0;
        m_ptr = 0;
        idle_inputs();
        s_v = '1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (obs_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b want=0000", obs_ready);
        end
        reset = 1'b0;
        idle_inputs();
        step();
        checks++;
        if (obs_v !== 4'b0000) begin
            failures++; $display("FAIL reset_rsp_valid got=%b want=0000", obs_v);
        end
        checks++;
        if (obs_d !== 64'h0) begin
            failures++; $display("FAIL reset_rsp_data got=%h want=0", obs_d);
        end
        checks++;
        if (obs_t !== 4'b0000) begin
            failures++; $display("FAIL reset_rsp_transparent got=%b want=0000", obs_t);
        end
    endtask

    task automatic test_single();
        idle_inputs();
        while (cyc < 10) step();
        s_v = 4'b0001; s_id[0] = 1; s_x[0] = 2; s_y[0] = 1;
        step();
        checks++;
        if (obs_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready got=%b want=0001", obs_ready);
        end
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (obs_v !== ((i == 3) ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL single_valid cyc=%0d got=%b", cyc - 1, obs_v);
            end
        end
        checks++;
        if (obs_d[15:0] !== 16'h0422 || obs_t[0] !== 1'b0) begin
            failures++; $display("FAIL single_data got=%h/%b want=0422/0", obs_d[15:0], obs_t[0]);
        end
    endtask

    task automatic test_all_channels();
        int cnt[NCH];
        for (int k = 0; k < NCH; k++) cnt[k] = 0;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                s_v = 4'b1111;
                for (int k = 0; k < NCH; k++) begin
                    s_id[k] = k; s_x[k] = i; s_y[k] = k + 4;
                end
            end else begin
                idle_inputs();
            end
            step();
            for (int k = 0; k < NCH; k++) cnt[k] += int'(obs_v[k]);
            checks++;
            if (i < 8 && obs_ready !== ((i % 2 == 0) ? 4'b0011 : 4'b1100)) begin
                failures++; $display("FAIL all_order i=%0d got=%b", i, obs_ready);
            end
            checks++;
            if (obs_ready !== exp_ready || obs_v !== exp_v || obs_d !== exp_d || obs_t !== exp_t) begin
                failures++;
                $display("FAIL all_model i=%0d rdy=%b/%b v=%b/%b d=%h/%h t=%b/%b", i,
                         obs_ready, exp_ready, obs_v, exp_v, obs_d, exp_d, obs_t, exp_t);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (cnt[k] != 4) begin
                failures++; $display("FAIL all_count ch=%0d got=%0d want=4", k, cnt[k]);
            end
        end
    endtask

    task automatic test_transparent();
        idle_inputs();
        s_v = 4'b0100; s_id[2] = 2; s_x[2] = 5; s_y[2] = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) idle_inputs();
            checks++;
            if (obs_v !== exp_v || obs_d !== exp_d || obs_t !== exp_t) begin
                failures++; $display("FAIL transp_model i=%0d v=%b/%b d=%h/%h", i, obs_v, exp_v, obs_d, exp_d);
            end
        end
        checks++;
        if (obs_v[2] !== 1'b1 || obs_d[47:32] !== 16'hF81F || obs_t[2] !== 1'b1) begin
            failures++; $display("FAIL transp_key got=%b/%h/%b want=1/f81f/1", obs_v[2], obs_d[47:32], obs_t[2]);
        end
    endtask

    task automatic test_oob();
        idle_inputs();
        s_v = 4'b0010; s_id[1] = 0; s_x[1] = 40; s_y[1] = 0;
        step();
        checks++;
        if (obs_ready[1] !== 1'b1) begin
            failures++; $display("FAIL oob_grant got=%b want=1", obs_ready[1]);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (obs_v !== 4'b0010 || obs_d[31:16] !== KEY || obs_t[1] !== 1'b1) begin
            failures++; $display("FAIL oob_rsp got=%b/%h/%b want=0010/f81f/1", obs_v, obs_d[31:16], obs_t[1]);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        s_v = 4'b0010; s_id[1] = 3; s_x[1] = 7; s_y[1] = 2;
        step();
        idle_inputs();
        s_v = 4'b0100; s_id[2] = 4; s_x[2] = 9; s_y[2] = 1;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_v = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (obs_ready !== 4'b0011) begin
                    failures++; $display("FAIL rstmid_ptr got=%b want=0011", obs_ready);
                end
                idle_inputs();
            end
            checks++;
            if (obs_v !== 4'b0000) begin
                failures++; $display("FAIL rstmid_squash i=%0d got=%b want=0000", i, obs_v);
            end
        end
        step();
        checks++;
        if (obs_v !== exp_v || obs_d !== exp_d || obs_t !== exp_t) begin
            failures++; $display("FAIL rstmid_model v=%b/%b d=%h/%h", obs_v, exp_v, obs_d, exp_d);
        end
    endtask

    task automatic test_ch3_only();
        idle_inputs();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                s_v = 4'b1000; s_id[3] = i % 8; s_x[3] = i * 3; s_y[3] = 31 - i;
            end else begin
                idle_inputs();
            end
            step();
            checks++;
            if (i < 8 && obs_ready !== 4'b1000) begin
                failures++; $display("FAIL ch3_ready i=%0d got=%b want=1000", i, obs_ready);
            end
            checks++;
            if (i >= 3 && (obs_v !== 4'b1000 || obs_d !== exp_d)) begin
                failures++; $display("FAIL ch3_rsp i=%0d v=%b d=%h want=%h", i, obs_v, obs_d, exp_d);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 304; i++) begin
            if (i < 300) begin
                s_v = 4'($urandom_range(0, 15));
                for (int k = 0; k < NCH; k++) begin
                    s_id[k] = $urandom_range(0, 7);
                    s_x[k]  = $urandom_range(0, 40);
                    s_y[k]  = $urandom_range(0, 40);
                end
                reset = ($urandom_range(0, 49) == 0);
            end else begin
                reset = 1'b0;
                idle_inputs();
            end
            step();
            checks++;
            if (obs_ready !== exp_ready || obs_v !== exp_v || obs_d !== exp_d || obs_t !== exp_t) begin
                failures++;
                $display("FAIL random i=%0d rdy=%b/%b v=%b/%b d=%h/%h t=%b/%b", i,
                         obs_ready, exp_ready, obs_v, exp_v, obs_d, exp_d, obs_t, exp_t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_transparent();
        test_oob();
        test_reset_mid();
        test_ch3_only();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
